// File: rtl/patch_row_dispatcher_if.sv
// Descriptor channel into the patch-row dispatcher.
//   master : descriptor producer (drives valid and payload, reads ready)
//   slave  : dispatcher (reads valid and payload, drives ready)
// Payload widths follow the reducer parameters so one descriptor maps 1:1 onto a
// reducer configuration.
interface patch_row_dispatcher_if #(
  parameter int unsigned N_PATCH    = 64,
  parameter int unsigned PATCH_SIZE = 4,
  parameter int unsigned N_COL_SIZE = 11,
  parameter int unsigned N_ROW_SIZE = 11,
  parameter int unsigned FP_SIZE    = 32
);
  logic                          desc_valid;
  logic                          desc_ready;
  logic [$clog2(N_PATCH)-1:0]    desc_num;
  logic [N_ROW_SIZE-1:0]         desc_row;
  logic [N_COL_SIZE-1:0]         desc_col;
  logic [PATCH_SIZE*FP_SIZE-1:0] desc_weights;

  modport master (
    output desc_valid, desc_num, desc_row, desc_col, desc_weights,
    input  desc_ready
  );

  modport slave (
    input  desc_valid, desc_num, desc_row, desc_col, desc_weights,
    output desc_ready
  );
endinterface

// File: rtl/patch_row_dispatcher.sv
// Patch-row dispatcher: accepts one patch-row descriptor at a time, finds a free
// reducer round-robin, broadcasts the registered configuration on conf_* and
// pulses a one-hot red_init for exactly one cycle to the chosen reducer.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   desc              descriptor channel (slave modport): valid/ready + payload
//   cur_row           row currently streaming to the reducers
//   frame_start       one-cycle new-frame pulse: clears counters and rr pointer
//   red_available     per-reducer free flags
//   red_init          one-hot init pulse (registered)
//   conf_*            configuration broadcast to all reducers, held outside ISSUE
//   n_issued          descriptors issued this frame (saturating)
//   n_missed          descriptors dropped this frame (saturating)
//   busy              high whenever the FSM is not idle
//
// Optional feature: DISPATCH_MISS_CHECK_EN. When defined, a held descriptor whose
// row is already behind cur_row is dropped in SEARCH and counted in n_missed.
// When undefined, no row comparison is made and n_missed is tied to zero.
module patch_row_dispatcher #(
  parameter int unsigned N_REDUCER  = 4,
  parameter int unsigned N_PATCH    = 64,
  parameter int unsigned PATCH_SIZE = 4,
  parameter int unsigned N_COL_SIZE = 11,
  parameter int unsigned N_ROW_SIZE = 11,
  parameter int unsigned FP_SIZE    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  patch_row_dispatcher_if.slave         desc,
  input  logic [N_ROW_SIZE-1:0]         cur_row,
  input  logic                          frame_start,
  input  logic [N_REDUCER-1:0]          red_available,
  output logic [N_REDUCER-1:0]          red_init,
  output logic [$clog2(N_PATCH)-1:0]    conf_num,
  output logic [N_ROW_SIZE-1:0]         conf_row,
  output logic [N_COL_SIZE-1:0]         conf_col,
  output logic [PATCH_SIZE*FP_SIZE-1:0] conf_weights,
  output logic [15:0]                   n_issued,
  output logic [15:0]                   n_missed,
  output logic                          busy
);

  localparam int unsigned NUM_W = $clog2(N_PATCH);
  localparam int unsigned W_W   = PATCH_SIZE * FP_SIZE;
  localparam int unsigned RR_W  = (N_REDUCER > 1) ? $clog2(N_REDUCER) : 1;

  typedef enum logic [1:0] {StIdle, StSearch, StIssue} state_e;

  state_e                state_q, state_d;
  logic [NUM_W-1:0]      hold_num_q, hold_num_d;
  logic [N_ROW_SIZE-1:0] hold_row_q, hold_row_d;
  logic [N_COL_SIZE-1:0] hold_col_q, hold_col_d;
  logic [W_W-1:0]        hold_weights_q, hold_weights_d;
  logic [NUM_W-1:0]      conf_num_q, conf_num_d;
  logic [N_ROW_SIZE-1:0] conf_row_q, conf_row_d;
  logic [N_COL_SIZE-1:0] conf_col_q, conf_col_d;
  logic [W_W-1:0]        conf_weights_q, conf_weights_d;
  logic [N_REDUCER-1:0]  red_init_q, red_init_d;
  logic [RR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [RR_W-1:0]       sel_q, sel_d;
  logic [15:0]           n_issued_q, n_issued_d;

  logic                  miss;
  logic                  found;
  logic [RR_W-1:0]       pick;
  logic [RR_W-1:0]       idx;

`ifdef DISPATCH_MISS_CHECK_EN
  logic [15:0] n_missed_q, n_missed_d;

  assign miss = (hold_row_q < cur_row);

  always_comb begin
    n_missed_d = n_missed_q;
    if (frame_start) begin
      n_missed_d = '0;
    end else if (state_q == StSearch && miss && n_missed_q != 16'hFFFF) begin
      n_missed_d = n_missed_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_missed_q <= '0;
    end else begin
      n_missed_q <= n_missed_d;
    end
  end

  assign n_missed = n_missed_q;
`else
  logic unused_cur_row;
  assign unused_cur_row = ^cur_row;
  assign miss           = 1'b0;
  assign n_missed       = 16'd0;
`endif

  // First available reducer at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REDUCER; i++) begin
      idx = RR_W'((32'(rr_ptr_q) + i) % N_REDUCER);
      if (!found && red_available[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    hold_num_d     = hold_num_q;
    hold_row_d     = hold_row_q;
    hold_col_d     = hold_col_q;
    hold_weights_d = hold_weights_q;
    conf_num_d     = conf_num_q;
    conf_row_d     = conf_row_q;
    conf_col_d     = conf_col_q;
    conf_weights_d = conf_weights_q;
    red_init_d     = '0;
    rr_ptr_d       = rr_ptr_q;
    sel_d          = sel_q;
    n_issued_d     = n_issued_q;

    unique case (state_q)
      StIdle: begin
        if (desc.desc_valid) begin
          hold_num_d     = desc.desc_num;
          hold_row_d     = desc.desc_row;
          hold_col_d     = desc.desc_col;
          hold_weights_d = desc.desc_weights;
          state_d        = StSearch;
        end
      end
      StSearch: begin
        // A late row is dropped before any reducer is considered.
        if (miss) begin
          state_d = StIdle;
        end else if (found) begin
          conf_num_d      = hold_num_q;
          conf_row_d      = hold_row_q;
          conf_col_d      = hold_col_q;
          conf_weights_d  = hold_weights_q;
          red_init_d[pick] = 1'b1;
          sel_d           = pick;
          state_d         = StIssue;
        end
      end
      StIssue: begin
        rr_ptr_d = RR_W'((32'(sel_q) + 32'd1) % N_REDUCER);
        if (n_issued_q != 16'hFFFF) begin
          n_issued_d = n_issued_q + 16'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // New frame wins over same-cycle counter and pointer updates; an in-flight
    // descriptor is left to complete.
    if (frame_start) begin
      rr_ptr_d   = '0;
      n_issued_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      hold_num_q     <= '0;
      hold_row_q     <= '0;
      hold_col_q     <= '0;
      hold_weights_q <= '0;
      conf_num_q     <= '0;
      conf_row_q     <= '0;
      conf_col_q     <= '0;
      conf_weights_q <= '0;
      red_init_q     <= '0;
      rr_ptr_q       <= '0;
      sel_q          <= '0;
      n_issued_q     <= '0;
    end else begin
      state_q        <= state_d;
      hold_num_q     <= hold_num_d;
      hold_row_q     <= hold_row_d;
      hold_col_q     <= hold_col_d;
      hold_weights_q <= hold_weights_d;
      conf_num_q     <= conf_num_d;
      conf_row_q     <= conf_row_d;
      conf_col_q     <= conf_col_d;
      conf_weights_q <= conf_weights_d;
      red_init_q     <= red_init_d;
      rr_ptr_q       <= rr_ptr_d;
      sel_q          <= sel_d;
      n_issued_q     <= n_issued_d;
    end
  end

  assign desc.desc_ready = (state_q == StIdle);
  assign busy            = (state_q != StIdle);
  assign red_init        = red_init_q;
  assign conf_num        = conf_num_q;
  assign conf_row        = conf_row_q;
  assign conf_col        = conf_col_q;
  assign conf_weights    = conf_weights_q;
  assign n_issued        = n_issued_q;

endmodule
